// File: rtl/zetas_addr_seq.sv
// Twiddle-address sequencer for the NTT unit: walks every layer/group of a Kyber or Dilithium
// (inverse) NTT, reads the zetas ROM under credit flow control and streams results from a FIFO.
module zetas_addr_seq #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  selKD_i,
  input  logic                  selNTT_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rom_valid_o,
  output logic                  rom_selKD_o,
  output logic                  rom_selNTT_o,
  output logic [ADDR_WIDTH-1:0] rom_addrX_o,
  output logic [ADDR_WIDTH-1:0] rom_addrY_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  zeta_valid_o,
  input  logic                  zeta_ready_i,
  output logic [DATA_WIDTH-1:0] zeta_o,
  output logic [3:0]            zeta_layer_o,
  output logic                  zeta_neg_o,
  output logic                  zeta_last_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough to hold count + in-flight request without overflow.
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1) + 1;
  localparam int unsigned EntW = DATA_WIDTH + 5;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e state_q, state_d;

  logic            sel_kd_q, sel_kd_d;
  logic            sel_ntt_q, sel_ntt_d;
  logic [2:0]      layer_q, layer_d;
  logic [6:0]      beat_q, beat_d;
  logic            inflight_q, inflight_d;
  logic [2:0]      tag_layer_q, tag_layer_d;
  logic            tag_neg_q, tag_neg_d;
  logic            tag_last_q, tag_last_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [EntW-1:0] fifo_q [FIFO_DEPTH];

  logic            push, pop, credit_ok, last_beat;
  logic [6:0]      beat_max;
  logic [2:0]      last_layer;
  logic [2:0]      shamt;
  logic [6:0]      jx, jy, gx, gy;
  logic [8:0]      pow2, kx, ky;
  logic [EntW-1:0] head;

  // ---------------------------------------------------------------------------------------------
  // Geometry: butterfly index j -> group g -> twiddle index k for the current layer and beat.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    shamt      = 3'd7 - layer_q;
    jx         = {beat_q[5:0], 1'b0};
    jy         = sel_kd_q ? {beat_q[5:0], 1'b1} : beat_q;
    gx         = jx >> shamt;
    gy         = jy >> shamt;
    pow2       = 9'd1 << layer_q;
    kx         = sel_ntt_q ? (pow2 + {2'b00, gx}) : ((pow2 << 1) - 9'd1 - {2'b00, gx});
    ky         = sel_ntt_q ? (pow2 + {2'b00, gy}) : ((pow2 << 1) - 9'd1 - {2'b00, gy});
    beat_max   = sel_kd_q ? 7'd63 : 7'd127;
    last_layer = sel_ntt_q ? (sel_kd_q ? 3'd6 : 3'd7) : 3'd0;
    last_beat  = (beat_q == beat_max) && (layer_q == last_layer);
  end

  // ---------------------------------------------------------------------------------------------
  // Credit: a request is only issued if the FIFO is guaranteed room when its data returns.
  // ---------------------------------------------------------------------------------------------
  assign zeta_valid_o = (count_q != '0);
  assign pop          = zeta_valid_o & zeta_ready_i;
  assign push         = inflight_q;
  assign credit_ok    = (count_q + CntW'(inflight_q)) < (CntW'(FIFO_DEPTH) + CntW'(pop));

  // ---------------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StRun;
      StRun:   if (rom_valid_o && last_beat) state_d = StDrain;
      StDrain: if ((count_q == '0) && !inflight_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != StIdle);
    rom_valid_o = (state_q == StRun) && credit_ok;
    done_o      = (state_q == StDrain) && (count_q == '0) && !inflight_q;
  end

  // ---------------------------------------------------------------------------------------------
  // Sequence counters, request tags and FIFO bookkeeping
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    sel_kd_d    = sel_kd_q;
    sel_ntt_d   = sel_ntt_q;
    layer_d     = layer_q;
    beat_d      = beat_q;
    if ((state_q == StIdle) && start_i) begin
      sel_kd_d  = selKD_i;
      sel_ntt_d = selNTT_i;
      beat_d    = 7'd0;
      layer_d   = selNTT_i ? 3'd0 : (selKD_i ? 3'd6 : 3'd7);
    end else if (rom_valid_o) begin
      if (beat_q == beat_max) begin
        beat_d  = 7'd0;
        layer_d = sel_ntt_q ? (layer_q + 3'd1) : (layer_q - 3'd1);
      end else begin
        beat_d  = beat_q + 7'd1;
      end
    end

    inflight_d  = rom_valid_o;
    tag_layer_d = rom_valid_o ? layer_q : tag_layer_q;
    tag_neg_d   = rom_valid_o ? !sel_ntt_q : tag_neg_q;
    tag_last_d  = rom_valid_o ? last_beat : tag_last_q;

    wr_ptr_d    = push ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
    rd_ptr_d    = pop ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
    count_d     = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sel_kd_q    <= 1'b0;
      sel_ntt_q   <= 1'b0;
      layer_q     <= 3'd0;
      beat_q      <= 7'd0;
      inflight_q  <= 1'b0;
      tag_layer_q <= 3'd0;
      tag_neg_q   <= 1'b0;
      tag_last_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      sel_kd_q    <= sel_kd_d;
      sel_ntt_q   <= sel_ntt_d;
      layer_q     <= layer_d;
      beat_q      <= beat_d;
      inflight_q  <= inflight_d;
      tag_layer_q <= tag_layer_d;
      tag_neg_q   <= tag_neg_d;
      tag_last_q  <= tag_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {rom_data_i, tag_layer_q, tag_neg_q, tag_last_q};
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  assign head         = fifo_q[rd_ptr_q];
  assign rom_selKD_o  = sel_kd_q;
  assign rom_selNTT_o = sel_ntt_q;
  assign rom_addrX_o  = (rom_valid_o && sel_kd_q) ? ADDR_WIDTH'(kx) : '0;
  assign rom_addrY_o  = rom_valid_o ? ADDR_WIDTH'(ky) : '0;
  assign zeta_o       = zeta_valid_o ? head[EntW-1:5] : '0;
  assign zeta_layer_o = zeta_valid_o ? {1'b0, head[4:2]} : 4'd0;
  assign zeta_neg_o   = zeta_valid_o & head[1];
  assign zeta_last_o  = zeta_valid_o & head[0];

endmodule
